// File: rtl/accumulator_pkg.sv
// Shared types and constants for the accumulator: FSM state encoding and
// two's complement saturation limits derived from the data width.
package accumulator_pkg;

    localparam int ACC_N_DEFAULT     = 22;
    localparam int ACC_LEN_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ADD,
        ST_CHECK,
        ST_DONE
    } state_e;

    function automatic logic signed [63:0] sat_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    localparam logic signed [ACC_N_DEFAULT-1:0] SAT_MAX = ACC_N_DEFAULT'(sat_max(ACC_N_DEFAULT));
    localparam logic signed [ACC_N_DEFAULT-1:0] SAT_MIN = ACC_N_DEFAULT'(sat_min(ACC_N_DEFAULT));

endpackage

// File: rtl/accumulator_if.sv
// Operand/result handshake bundle between the accumulator and its environment.
interface accumulator_if
    import accumulator_pkg::*;
#(
    parameter int N     = ACC_N_DEFAULT,
    parameter int LEN_W = ACC_LEN_W_DEFAULT
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    in_valid;
    logic signed [N-1:0]     in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [N-1:0]     out_data;
    logic                    out_ovf;
    logic                    busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/accumulator_adder.sv
// Single-cycle fixed-point adder: registers the wrapped sum and a signed
// overflow flag whenever refresh is high, otherwise holds its outputs.
module accumulator_adder #(
    parameter int N = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                refresh,
    input  logic signed [N-1:0] input_q_1,
    input  logic signed [N-1:0] input_q_2,
    output logic signed [N-1:0] output_q,
    output logic                overflow
);
    logic signed [N-1:0] w_sum;
    logic                w_ovf;

    assign w_sum = input_q_1 + input_q_2;
    // Overflow: both operands share a sign that the wrapped sum does not.
    assign w_ovf = (input_q_1[N-1] == input_q_2[N-1]) && (w_sum[N-1] != input_q_1[N-1]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_q <= '0;
            overflow <= 1'b0;
        end else if (refresh) begin
            output_q <= w_sum;
            overflow <= w_ovf;
        end
    end
endmodule

// File: rtl/accumulator.sv
// Handshaked run-length accumulator: sums len signed operands through a
// registered adder. Define ACCUMULATOR_SAT_EN to saturate instead of wrap.
module accumulator
    import accumulator_pkg::*;
#(
    parameter int N     = ACC_N_DEFAULT,
    parameter int LEN_W = ACC_LEN_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    accumulator_if.slave  bus
);
`ifdef ACCUMULATOR_SAT_EN
    localparam logic signed [N-1:0] L_SAT_MAX = N'(sat_max(N));
    localparam logic signed [N-1:0] L_SAT_MIN = N'(sat_min(N));
`endif

    state_e              r_state;
    state_e              w_state_nxt;
    logic signed [N-1:0] r_acc;
    logic signed [N-1:0] r_op;
    logic [LEN_W-1:0]    r_count;
    logic [LEN_W-1:0]    r_len;
    logic                r_ovf;

    logic signed [N-1:0] w_sum;
    logic                w_add_ovf;
    logic [LEN_W-1:0]    w_count_inc;
    logic                w_last;
    logic                w_refresh;
    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_busy;

    accumulator_adder #(.N(N)) u_adder (
        .clk       (clk),
        .rst_n     (rst_n),
        .refresh   (w_refresh),
        .input_q_1 (r_acc),
        .input_q_2 (r_op),
        .output_q  (w_sum),
        .overflow  (w_add_ovf)
    );

    // count only ever reaches len-1 before the run ends, so the increment cannot wrap.
    assign w_count_inc = r_count + LEN_W'(1);
    assign w_last      = (w_count_inc == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_refresh   = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_nxt = (bus.len == '0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = ST_ADD;
            end
            ST_ADD: begin
                w_refresh   = 1'b1;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: w_state_nxt = w_last ? ST_DONE : ST_WAIT;
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all datapath registers, including the operand and length holders,
    // are reset so a mid-run reset leaves no stale run behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_op    <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_acc   <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_len   <= bus.len;
                end
                ST_WAIT: if (bus.in_valid) r_op <= bus.in_data;
                ST_CHECK: begin
                    r_count <= w_count_inc;
                    if (w_add_ovf) begin
                        r_ovf <= 1'b1;
`ifdef ACCUMULATOR_SAT_EN
                        r_acc <= r_op[N-1] ? L_SAT_MIN : L_SAT_MAX;
`else
                        r_acc <= w_sum;
`endif
                    end else begin
                        r_acc <= w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_data  = w_out_valid ? r_acc : '0;
    assign bus.out_ovf   = w_out_valid & r_ovf;
endmodule

// File: tb/tb_accumulator.sv
// Self-checking bench for accumulator: directed and randomized runs checked
// against an integer-arithmetic model; honours ACCUMULATOR_SAT_EN.
module tb_accumulator;
    localparam int     N      = 22;
    localparam int     LEN_W  = 8;
    localparam int     BUDGET = 3000;
    localparam longint MAXV   = (64'sd1 <<< (N - 1)) - 64'sd1;
    localparam longint MINV   = -(64'sd1 <<< (N - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    accumulator_if #(.N(N), .LEN_W(LEN_W)) bus ();
    accumulator #(.N(N), .LEN_W(LEN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: exact integer sum, with overflow judged against the N-bit range.
    function automatic void model(input int ops[$], output longint res, output bit ovf);
        longint acc;
        longint s;
        acc = 0;
        ovf = 1'b0;
        foreach (ops[i]) begin
            s = acc + longint'(ops[i]);
            if (s > MAXV || s < MINV) begin
                ovf = 1'b1;
`ifdef ACCUMULATOR_SAT_EN
                acc = (ops[i] >= 0) ? MAXV : MINV;
`else
                acc = (s > MAXV) ? s - (64'sd1 <<< N) : s + (64'sd1 <<< N);
`endif
            end else begin
                acc = s;
            end
        end
        res = acc;
    endfunction

    function automatic int rand_op();
        logic signed [N-1:0] v;
        v = N'($urandom);
        if ($urandom_range(0, 1) == 0) v = N'($signed($urandom_range(0, 200)) - 100);
        return int'(v);
    endfunction

    // Called at posedge+1 with the DUT idle; runs one accumulation end to end.
    task automatic do_run(input int len_v, input int ops[$], input bit gaps, input bit noise,
                          input int out_delay, input int exp_lat, input string name,
                          output logic signed [N-1:0] got_data, output logic got_ovf);
        longint              res;
        bit                  m_ovf;
        logic signed [N-1:0] exp_d;
        int                  cyc;
        int                  idx;
        bit                  hs;
        model(ops, res, m_ovf);
        exp_d    = N'(res);
        got_data = '0;
        got_ovf  = 1'b0;
        bus.start = 1'b1;
        bus.len   = LEN_W'(len_v);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        idx = 0;
        while (!bus.out_valid && cyc < BUDGET) begin
            if (bus.in_ready) begin
                bus.in_valid = (idx < ops.size()) && (!gaps || $urandom_range(0, 2) != 0);
                bus.in_data  = (idx < ops.size()) ? N'(ops[idx]) : N'($urandom);
            end else begin
                bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : (idx < ops.size());
                bus.in_data  = (gaps || idx >= ops.size()) ? N'($urandom) : N'(ops[idx]);
            end
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.len   = LEN_W'($urandom);
            end
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        n_checks++;
        if (!bus.out_valid) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid still %b after %0d cycles, required 1", name, bus.out_valid, cyc);
            return;
        end
        got_data = bus.out_data;
        got_ovf  = bus.out_ovf;
        if (got_data !== exp_d || got_ovf !== m_ovf || idx != ops.size()) begin
            n_fail++;
            $display("FAIL %s result: got data %0d ovf %b after %0d operands, required data %0d ovf %b after %0d",
                     name, got_data, got_ovf, idx, exp_d, m_ovf, ops.size());
        end
        if (exp_lat >= 0) begin
            n_checks++;
            if (cyc != exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_lat);
            end
        end
        for (int k = 0; k < out_delay; k++) begin
            bus.out_ready = 1'b0;
            bus.start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.len       = LEN_W'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== got_data || bus.out_ovf !== got_ovf || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hold %0d: got valid %b data %0d ovf %b busy %b, required 1 %0d %b 1",
                         name, k, bus.out_valid, bus.out_data, bus.out_ovf, bus.busy, got_data, got_ovf);
            end
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: got valid %b busy %b, required 0 0", name, bus.out_valid, bus.busy);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_ovf !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got ready %b valid %b data %0d ovf %b busy %b, required all 0",
                     name, bus.in_ready, bus.out_valid, bus.out_data, bus.out_ovf, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        #1;
        check_outputs_zero("after_release");
    endtask

    task automatic test_basic();
        int                  q[$];
        logic signed [N-1:0] d;
        logic                o;
        q.push_back(1); q.push_back(2); q.push_back(3);
        do_run(3, q, 1'b0, 1'b0, 0, 10, "basic_123", d, o);
        n_checks++;
        if (d !== 22'sd6 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_const: got %0d/%b, required 6/0", d, o);
        end
    endtask

    task automatic test_overflow();
        int                  q[$];
        logic signed [N-1:0] d;
        logic signed [N-1:0] e1;
        logic signed [N-1:0] e2;
        logic                o;
`ifdef ACCUMULATOR_SAT_EN
        e1 = 22'sd2097151;
        e2 = -22'sd2097152;
`else
        e1 = -22'sd2097152;
        e2 = 22'sd2097151;
`endif
        q.push_back(2097151); q.push_back(1);
        do_run(2, q, 1'b0, 1'b0, 1, 7, "ovf_pos", d, o);
        n_checks++;
        if (d !== e1 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pos_const: got %0d/%b, required %0d/1", d, o, e1);
        end
        q.delete(); q.push_back(-2097152); q.push_back(-1);
        do_run(2, q, 1'b0, 1'b0, 0, 7, "ovf_neg", d, o);
        n_checks++;
        if (d !== e2 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_neg_const: got %0d/%b, required %0d/1", d, o, e2);
        end
        q.delete(); q.push_back(5); q.push_back(-7);
        do_run(2, q, 1'b0, 1'b0, 0, 7, "sticky_clear", d, o);
        n_checks++;
        if (d !== -22'sd2 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_clear_const: got %0d/%b, required -2/0", d, o);
        end
    endtask

    task automatic test_len0();
        int                  q[$];
        logic signed [N-1:0] d;
        logic                o;
        q.delete();
        do_run(0, q, 1'b0, 1'b1, 5, 1, "len0", d, o);
    endtask

    task automatic test_random();
        int                  q[$];
        int                  l;
        logic signed [N-1:0] d;
        logic                o;
        for (int r = 0; r < 10; r++) begin
            q.delete();
            l = $urandom_range(1, 12);
            for (int i = 0; i < l; i++) q.push_back(rand_op());
            do_run(l, q, 1'b1, 1'b1, $urandom_range(0, 3), -1, $sformatf("random_%0d", r), d, o);
        end
    endtask

    task automatic test_max_len();
        int                  q[$];
        logic signed [N-1:0] d;
        logic                o;
        for (int i = 0; i < 255; i++) q.push_back(rand_op());
        do_run(255, q, 1'b0, 1'b0, 0, 766, "max_len", d, o);
    endtask

    task automatic test_reset_mid_run();
        int                  q[$];
        logic signed [N-1:0] d;
        logic                o;
        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 22'sd100;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_pre: got busy %b ready %b, required 1 0", bus.busy, bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_run_reset");
        @(posedge clk); @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        q.push_back(-9);
        do_run(1, q, 1'b0, 1'b0, 0, 4, "post_reset", d, o);
        n_checks++;
        if (d !== -22'sd9 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_const: got %0d/%b, required -9/0", d, o);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_basic();
        test_overflow();
        test_len0();
        test_random();
        test_max_len();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 Parameter N, 22, data width in bits, 2's complement fixed-point.
REQ-002 Parameter LEN_W, 8, width of the operand-count input.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins an accumulation; honoured only in IDLE.
REQ-006 len  input  LEN_W  number of operands to sum; sampled only on an accepted start.
REQ-007 in_valid  input  1  operand valid.
REQ-008 in_data  input  signed N  operand.
REQ-009 in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 out_data  output  signed N  accumulated sum.
REQ-013 out_ovf  output  1  sticky flag: at least one addition in this run overflowed.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, WAIT, ADD, CHECK, DONE.
REQ-016 IDLE -> WAIT on start when len != 0, and -> DONE on start when len == 0; either transition clears acc, count and the sticky overflow flag.
REQ-017 WAIT: in_ready = 1; on handshake, latch in_data into operand register op, -> ADD.
REQ-018 ADD: drive sub-adder with input_q_1 = acc, input_q_2 = op, refresh = 1; -> CHECK.
REQ-019 CHECK: refresh = 0, adder inputs held; read adder output_q and overflow; update acc; increment count; -> DONE if count+1 == len, else -> WAIT.
REQ-020 Throughput: minimum 3 cycles per operand; operand accepted at edge E0 appears in acc at edge E0+2.
REQ-021 DONE: out_valid = 1, out_data = acc, out_ovf = sticky flag, all stable until the handshake; on out_valid && out_ready -> IDLE.
REQ-022 The adder is plain integer addition with no rescaling; the operands share one fixed-point format.
REQ-023 start outside IDLE is ignored; in_valid outside WAIT is ignored and in_data is not consumed.
REQ-024 in_ready, out_valid and refresh are decoded from the state register only and are glitch-free registered-state decodes.
REQ-025 len = 2^LEN_W - 1 is the maximum run length; count is LEN_W bits wide and never wraps within a run.

Reset
REQ-026 On rst_n low, at any time including mid-run: state = IDLE; acc, op, count and the sticky flag = 0; outputs are in_ready 0, out_valid 0, out_data 0, out_ovf 0, busy 0; the sub-adder is reset by the same rst_n.
REQ-027 After reset release, the first start is honoured on the first posedge following deassertion.

Configuration
REQ-028 With macro ACCUMULATOR_SAT_EN defined: on overflow in CHECK, acc loads +max (2^(N-1)-1) when op is non-negative and -min (-2^(N-1)) when op is negative, and the sticky flag is set.
REQ-029 Without ACCUMULATOR_SAT_EN: acc loads the wrapped adder output unchanged and the sticky flag is still set.

Structure
REQ-030 Shared package accumulator_pkg holds the FSM state enum and the saturation constants, derived from N.
REQ-031 One sub-module: the existing single-cycle fixed-point adder, with N passed through, clk/rst_n shared, and refresh driven by the ADD state.

Verification
REQ-032 len=3, operands 1, 2, 3 -> out_data=6, out_ovf=0, out_valid first high 10 cycles after start when in_valid is held high.
REQ-033 len=2, operands 2097151, 1 -> with SAT_EN: out_data=2097151, out_ovf=1; without: out_data=-2097152, out_ovf=1.
REQ-034 len=2, operands -2097152, -1 with SAT_EN -> out_data=-2097152, out_ovf=1; a following run of 5, -7 -> out_data=-2, out_ovf=0 (sticky flag cleared by start).
REQ-035 len=0 start -> DONE on the next cycle with out_data=0, out_ovf=0; out_ready held low for 5 cycles -> out_valid and out_data stable, busy=1; start pulses during this time are ignored.
REQ-036 rst_n asserted during CHECK of a len=4 run -> all outputs 0 within the same cycle; a new run (len=1, operand -9) -> out_data=-9.
